// File: rtl/user_uart_rx.sv
// Naive_bus slave that receives serial bytes on the user UART RX pin and buffers them in a FIFO.
// Define USER_UART_RX_PARITY_EN to receive 8E1 frames with parity checking; the default is 8N1.
module user_uart_rx #(
    parameter int CLK_DIV         = 434,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_uart_rx,
    input  logic        bus_rd_req,
    output logic        bus_rd_gnt,
    input  logic [31:0] bus_rd_addr,
    output logic [31:0] bus_rd_data,
    input  logic        bus_wr_req,
    output logic        bus_wr_gnt,
    input  logic [31:0] bus_wr_addr,
    input  logic [31:0] bus_wr_data,
    input  logic [3:0]  bus_wr_be
);

    localparam int AW    = FIFO_DEPTH_LOG2;
    localparam int DEPTH = 1 << AW;
    localparam logic [15:0] HALF_RELOAD = 16'(CLK_DIV / 2 - 1);
    localparam logic [15:0] BIT_RELOAD  = 16'(CLK_DIV - 1);
    localparam logic [AW:0] DEPTH_CNT   = {1'b1, {AW{1'b0}}};

`ifdef USER_UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
    } state_t;
`endif

    function automatic logic [4:0] sat_count(input logic [AW:0] c);
        logic [31:0] w;
        w = 32'(c);
        return (w > 32'd31) ? 5'd31 : w[4:0];
    endfunction

    // ---------------- synchronizer ----------------
    logic       rx_meta, rx_sync, rx_prev;
    logic [1:0] settle;
    logic       fall_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
            settle  <= 2'd0;
        end else begin
            rx_meta <= i_uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            if (settle != 2'd3)
                settle <= settle + 2'd1;
        end
    end

    // The reset value of the flops is not a real line sample, so edges are only
    // trusted once the pipeline has been refilled from the pin after reset.
    assign fall_edge = (settle == 2'd3) && rx_prev && !rx_sync;

    // ---------------- receive FSM ----------------
    state_t      state, state_nx;
    logic [15:0] cnt, cnt_nx;
    logic [2:0]  bit_idx, bit_nx;
    logic [7:0]  shift, shift_nx;
    logic        expired;
    logic        push_req;
    logic        par_flag;
`ifdef USER_UART_RX_PARITY_EN
    logic        par_bad, par_bad_nx;
    logic        par_set;
`endif

    assign expired = (cnt == 16'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= 16'd0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
`ifdef USER_UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_idx <= bit_nx;
            shift   <= shift_nx;
`ifdef USER_UART_RX_PARITY_EN
            par_bad <= par_bad_nx;
`endif
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = expired ? cnt : cnt - 16'd1;
        bit_nx   = bit_idx;
        shift_nx = shift;
        push_req = 1'b0;
`ifdef USER_UART_RX_PARITY_EN
        par_bad_nx = par_bad;
        par_set    = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (fall_edge) begin
                    cnt_nx   = HALF_RELOAD;
                    state_nx = S_START;
                end
            end
            S_START: begin
                if (expired) begin
                    if (rx_sync) begin
                        state_nx = S_IDLE;
                    end else begin
                        cnt_nx   = BIT_RELOAD;
                        bit_nx   = 3'd0;
                        state_nx = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (expired) begin
                    shift_nx = {rx_sync, shift[7:1]};
                    cnt_nx   = BIT_RELOAD;
                    if (bit_idx == 3'd7) begin
`ifdef USER_UART_RX_PARITY_EN
                        state_nx = S_PARITY;
`else
                        state_nx = S_STOP;
`endif
                    end else begin
                        bit_nx = bit_idx + 3'd1;
                    end
                end
            end
`ifdef USER_UART_RX_PARITY_EN
            S_PARITY: begin
                if (expired) begin
                    par_bad_nx = ^{shift, rx_sync};
                    par_set    = ^{shift, rx_sync};
                    cnt_nx     = BIT_RELOAD;
                    state_nx   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (expired) begin
                    if (rx_sync) begin
`ifdef USER_UART_RX_PARITY_EN
                        push_req = !par_bad;
`else
                        push_req = 1'b1;
`endif
                        state_nx = S_IDLE;
                    end else begin
                        state_nx = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rx_sync)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // ---------------- FIFO and bus ----------------
    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, fifo_cnt;
    logic        fifo_empty, fifo_full;
    logic        pop, push_ok, ovf_set;
    logic        wr_ctrl, flush, clr_flags;
    logic        ovf_flag;
    logic [7:0]  head;
    logic        unused_bus;

    assign bus_rd_gnt = bus_rd_req;
    assign bus_wr_gnt = bus_wr_req;
    assign unused_bus = &{1'b0, bus_rd_addr, bus_wr_addr, bus_wr_data[31:2], bus_wr_be[3:1]};

    assign fifo_cnt   = wr_ptr - rd_ptr;
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == DEPTH_CNT);
    assign head       = fifo_empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

    assign wr_ctrl   = bus_wr_req && bus_wr_be[0];
    assign flush     = wr_ctrl && bus_wr_data[0];
    assign clr_flags = wr_ctrl && (bus_wr_data[0] || bus_wr_data[1]);

    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign pop     = bus_rd_req && !fifo_empty;
    assign push_ok = push_req && !flush && (!fifo_full || pop);
    assign ovf_set = push_req && fifo_full && !pop && !clr_flags;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ovf_flag <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
            end
            if (clr_flags)
                ovf_flag <= 1'b0;
            else if (ovf_set)
                ovf_flag <= 1'b1;
        end
    end

`ifdef USER_UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            par_flag <= 1'b0;
        else if (clr_flags)
            par_flag <= 1'b0;
        else if (par_set)
            par_flag <= 1'b1;
    end
`else
    assign par_flag = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr[AW-1:0]] <= shift;
    end

    // Read word reflects the state before any same-cycle pop, push or write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bus_rd_data <= 32'h0;
        else if (bus_rd_req)
            bus_rd_data <= {16'h0, sat_count(fifo_cnt), par_flag, ovf_flag, !fifo_empty, head};
    end

endmodule

// File: tb/tb_user_uart_rx.sv
// Randomized self-checking bench for user_uart_rx against a queue-based model of the receiver and FIFO.
module tb_user_uart_rx;

    localparam int CLK_DIV = 16;
    localparam int DEPTH   = 16;
`ifdef USER_UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        rd_req = 1'b0, wr_req = 1'b0;
    logic        rd_gnt, wr_gnt;
    logic [31:0] rd_addr = 32'h0, wr_addr = 32'h0, wr_data = 32'h0, rd_data;
    logic [3:0]  wr_be = 4'h0;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] model_q[$];
    bit         model_ovf = 1'b0;
    bit         model_par = 1'b0;

    user_uart_rx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH_LOG2(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_uart_rx  (rx),
        .bus_rd_req (rd_req),
        .bus_rd_gnt (rd_gnt),
        .bus_rd_addr(rd_addr),
        .bus_rd_data(rd_data),
        .bus_wr_req (wr_req),
        .bus_wr_gnt (wr_gnt),
        .bus_wr_addr(wr_addr),
        .bus_wr_data(wr_data),
        .bus_wr_be  (wr_be)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] model_word();
        int         n;
        logic [4:0] c;
        logic [7:0] h;
        n = model_q.size();
        c = (n > 31) ? 5'd31 : 5'(n);
        h = (n != 0) ? model_q[0] : 8'h00;
        return {16'h0, c, model_par, model_ovf, (n != 0), h};
    endfunction

    task automatic bit_time(input logic v);
        rx = v;
        repeat (CLK_DIV) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
        @(negedge clk);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++)
            bit_time(d[i]);
        if (PAR_EN)
            bit_time((^d) ^ par_flip);
        bit_time(stop_bit);
        rx = 1'b1;
        if (PAR_EN && par_flip)
            model_par = 1'b1;
        else if (stop_bit) begin
            if (model_q.size() >= DEPTH)
                model_ovf = 1'b1;
            else
                model_q.push_back(d);
        end
        if (!stop_bit)
            repeat (2 * CLK_DIV) @(negedge clk);
    endtask

    task automatic do_read(input string tag, output logic [31:0] w);
        logic [31:0] exp;
        @(negedge clk);
        exp     = model_word();
        rd_req  = 1'b1;
        rd_addr = $urandom;
        #1 check({tag, "_gnt"}, {31'h0, rd_gnt}, 32'h1);
        @(posedge clk);
        #1 rd_req = 1'b0;
        w = rd_data;
        check(tag, w, exp);
        if (model_q.size() != 0)
            void'(model_q.pop_front());
    endtask

    task automatic do_write(input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        wr_req  = 1'b1;
        wr_data = d;
        wr_be   = be;
        wr_addr = $urandom;
        #1 check("wr_gnt", {31'h0, wr_gnt}, 32'h1);
        @(posedge clk);
        #1 wr_req = 1'b0;
        if (be[0] && d[0]) begin
            model_q.delete();
            model_ovf = 1'b0;
            model_par = 1'b0;
        end else if (be[0] && d[1]) begin
            model_ovf = 1'b0;
            model_par = 1'b0;
        end
    endtask

    task automatic glitch(input int len);
        @(negedge clk);
        rx = 1'b0;
        repeat (len) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CLK_DIV) @(negedge clk);
    endtask

    initial begin
        logic [31:0] w;
        logic [7:0]  d;
        int          r;

        repeat (3) @(negedge clk);
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_rd_gnt", {31'h0, rd_gnt}, 32'h0);
        check("rst_wr_gnt", {31'h0, wr_gnt}, 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        send_frame(8'hA5, 1'b1, 1'b0);
        do_read("a5", w);
        check("a5_word", w, 32'h0000_09A5);
        do_read("a5_empty", w);
        check("a5_empty_word", w, 32'h0);

        for (int i = 1; i <= 17; i++)
            send_frame(8'(i), 1'b1, 1'b0);
        do_read("ovf_first", w);
        check("ovf_first_word", w, 32'h0000_8301);
        for (int i = 2; i <= 16; i++)
            do_read("ovf_drain", w);
        do_read("ovf_after", w);
        check("ovf_after_word", w, 32'h0000_0200);
        do_write(32'h2, 4'b0001);
        do_read("ovf_cleared", w);

        glitch(6);
        do_read("glitch", w);
        check("glitch_word", w, 32'h0);

        send_frame(8'h3C, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b0);
        do_read("frame_recover", w);
        check("frame_recover_word", w, 32'h0000_095A);

        for (int i = 0; i < 3; i++)
            send_frame(8'($urandom), 1'b1, 1'b0);
        do_write(32'h1, 4'b0001);
        do_read("flush", w);
        check("flush_word", w, 32'h0);

        for (int i = 0; i < 17; i++)
            send_frame(8'(8'h40 + i), 1'b1, 1'b0);
        do_write(32'h2, 4'b0001);
        for (int i = 0; i < 17; i++)
            do_read("clr_keep", w);

        send_frame(8'h11, 1'b1, 1'b0);
        @(negedge clk);
        bit_time(1'b0);
        for (int i = 0; i < 4; i++)
            bit_time(i[0]);
        rx    = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_rd_data", rd_data, 32'h0);
        rst_n = 1'b1;
        model_q.delete();
        model_ovf = 1'b0;
        model_par = 1'b0;
        repeat (2 * CLK_DIV) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CLK_DIV) @(negedge clk);
        do_read("midrst_empty", w);
        check("midrst_empty_word", w, 32'h0);
        send_frame(8'h7E, 1'b1, 1'b0);
        do_read("midrst_7e", w);
        check("midrst_7e_word", w, 32'h0000_097E);

`ifdef USER_UART_RX_PARITY_EN
        send_frame(8'h03, 1'b1, 1'b1);
        do_read("par_bad", w);
        check("par_bad_word", w, 32'h0000_0400);
        do_write(32'h2, 4'b0001);
        send_frame(8'h03, 1'b1, 1'b0);
        do_read("par_ok", w);
        check("par_ok_word", w, 32'h0000_0903);
`endif

        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 11);
            d = 8'($urandom);
            if (r <= 5)
                send_frame(d, 1'b1, ($urandom_range(0, 7) == 0));
            else if (r == 6)
                send_frame(d, 1'b0, 1'b0);
            else if (r <= 9)
                do_read("rand_rd", w);
            else if (r == 10)
                glitch($urandom_range(1, CLK_DIV / 2 - 2));
            else
                do_write({30'h0, 2'($urandom)}, 4'($urandom));
        end
        while (model_q.size() != 0)
            do_read("final_drain", w);
        do_read("final_empty", w);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
